uart_pixel_framer: RTL

Parametrised successor to the fixed 3-byte RGB packer and bit-slice output stage that sit between the UART and the image pipeline.
- Ingress: packs channels_p UART bytes into one pixel word through a registered, backpressure-correct handshake. Tracks column and row, and emits sof/eol/frame_done markers.
- Egress: converts a mag_width_p-bit magnitude into one saturated UART byte with a programmable right shift.
- Placement: between uart (rx/tx AXIS) and the rgb2gray/sobel/mag chain.

---
 rtl/uart_pixel_framer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_pixel_framer.sv
// UART <-> image pipeline framer: packs channels_p rx bytes into pixels with
// col/row markers, and saturates magnitudes into tx bytes. Optional macro
// PIXEL_FRAMER_TIMEOUT_EN drops a stalled partial pixel after an idle period.
module uart_pixel_framer #(
  parameter int channels_p       = 3,
  parameter int width_p          = 8,
  parameter int linewidth_px_p   = 480,
  parameter int frame_lines_p    = 272,
  parameter int mag_width_p      = 16,
  parameter int mag_rshift_p     = 2,
  parameter int timeout_cycles_p = 100000
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [width_p-1:0]            data_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [channels_p*width_p-1:0] pixel_o,
  output logic                          sof_o,
  output logic                          eol_o,
  output logic                          frame_done_o,
  input  logic                          mag_valid_i,
  output logic                          mag_ready_o,
  input  logic [mag_width_p-1:0]        mag_i,
  output logic                          byte_valid_o,
  input  logic                          byte_ready_i,
  output logic [width_p-1:0]            byte_o
);

  // Every interface moves a word when valid and ready are both high at a rising
  // edge; a raised valid holds its data stable until that transfer happens.

  localparam int PIX_W = channels_p * width_p;
  localparam int IDX_W = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int COL_W = (linewidth_px_p > 1) ? $clog2(linewidth_px_p) : 1;
  localparam int ROW_W = (frame_lines_p > 1) ? $clog2(frame_lines_p) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(channels_p - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(linewidth_px_p - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(frame_lines_p - 1);
  localparam logic [mag_width_p-1:0] BYTE_MAX =
    mag_width_p'((64'd1 << width_p) - 64'd1);

  if (channels_p < 1 || channels_p > 4 || mag_width_p < width_p ||
      timeout_cycles_p < 2) begin : g_bad_params
    $error("uart_pixel_framer: unsupported parameter combination");
  end

  // ---------------------------------------------------------------------------
  // Ingress state
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic             last_byte;
  logic             accept;
  logic             load;
  logic             pix_hs;
  logic             timeout_hit;
  logic [PIX_W-1:0] load_word;

  assign last_byte = (idx_q == LAST_IDX);
  assign ready_o   = last_byte ? (!valid_q || ready_i) : 1'b1;
  assign accept    = valid_i && ready_o;
  assign load      = accept && last_byte;
  assign pix_hs    = valid_q && ready_i;

`ifdef PIXEL_FRAMER_TIMEOUT_EN
  localparam int TMO_W = $clog2(timeout_cycles_p + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles_p - 1);

  logic [TMO_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q + 1'b1;
    if (accept || idx_q == '0) begin
      idle_d = '0;
    end
  end

  // A byte arriving on the expiry cycle still counts; alignment is only
  // abandoned when the line has truly gone quiet mid-pixel.
  assign timeout_hit = !accept && (idx_q != '0) && (idle_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // The top slot of the hold register is never stored; the last byte goes
  // straight from data_i into the output register.
  always_comb begin
    load_word = hold_q;
    load_word[int'(LAST_IDX)*width_p +: width_p] = data_i;
  end

  always_comb begin
    idx_d  = idx_q;
    hold_d = hold_q;
    if (accept) begin
      if (last_byte) begin
        idx_d = '0;
      end else begin
        hold_d[int'(idx_q)*width_p +: width_p] = data_i;
        idx_d = idx_q + 1'b1;
      end
    end else if (timeout_hit) begin
      idx_d  = '0;
      hold_d = '0;
    end
  end

  // Position of the pixel presented (or next to be presented) on pixel_o.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_hs) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // A load takes the position after any handshake in the same cycle, so a
  // back-to-back reload gets markers for the following pixel.
  always_comb begin
    valid_d = valid_q;
    pixel_d = pixel_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    if (load) begin
      valid_d = 1'b1;
      pixel_d = load_word;
      sof_d   = (col_d == '0) && (row_d == '0);
      eol_d   = (col_d == LAST_COL);
    end else if (pix_hs) begin
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
    end
  end

  assign frame_done_o = pix_hs && (col_q == LAST_COL) && (row_q == LAST_ROW);
  assign valid_o      = valid_q;
  assign pixel_o      = pixel_q;
  assign sof_o        = sof_q;
  assign eol_o        = eol_q;

  // ---------------------------------------------------------------------------
  // Egress: magnitude -> saturated byte
  // ---------------------------------------------------------------------------
  logic                   byte_valid_q, byte_valid_d;
  logic [width_p-1:0]     byte_q, byte_d;
  logic [mag_width_p-1:0] mag_scaled;
  logic [width_p-1:0]     byte_sat;
  logic                   mag_accept;

  assign mag_ready_o = !byte_valid_q || byte_ready_i;
  assign mag_accept  = mag_valid_i && mag_ready_o;
  assign mag_scaled  = mag_i >> mag_rshift_p;
  assign byte_sat    = (mag_scaled > BYTE_MAX) ? {width_p{1'b1}}
                                               : mag_scaled[width_p-1:0];

  always_comb begin
    byte_valid_d = byte_valid_q;
    byte_d       = byte_q;
    if (mag_accept) begin
      byte_valid_d = 1'b1;
      byte_d       = byte_sat;
    end else if (byte_ready_i) begin
      byte_valid_d = 1'b0;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q        <= '0;
      hold_q       <= '0;
      valid_q      <= 1'b0;
      pixel_q      <= '0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
    end else begin
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      valid_q      <= valid_d;
      pixel_q      <= pixel_d;
      sof_q        <= sof_d;
      eol_q        <= eol_d;
      col_q        <= col_d;
      row_q        <= row_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
    end
  end

endmodule
